// File: rtl/clock_divider_bank.sv
// Bank of runtime-programmable 50%-duty clock dividers, each with a rising-edge tick.
// Latency: all outputs registered; clk_out rises H edges after enable, sync or reset release.
// Backpressure: none; config writes are always accepted and applied at a glitch-free point.
module clock_divider_bank #(
    parameter int  NUM_CH     = 2,
    parameter int  CNT_W      = 16,
    parameter int  RESET_HALF = 5,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock1M,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] act_h;
        logic [CNT_W-1:0] pend_h;
        logic [CNT_W-1:0] cnt;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             wr_hit;
        logic             run;
        logic             tc;
        logic             fall_tc;

        // Out-of-range channel numbers never match any i, so they are dropped here.
        assign wr_hit  = cfg_we && (int'(cfg_ch) == i);
        assign run     = en[i] && (act_h != '0);
        assign tc      = (cnt == act_h - CNT_W'(1));
        assign fall_tc = run && tc && clk_q;

        always_ff @(posedge clock1M) begin
            if (reset) begin
                act_h  <= CNT_W'(RESET_HALF);
                pend_h <= '0;
                pend   <= 1'b0;
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                // A write landing on an apply edge takes effect on that same edge.
                if (sync || fall_tc) begin
                    if (wr_hit) begin
                        act_h <= cfg_half;
                    end else if (pend) begin
                        act_h <= pend_h;
                    end
                    pend <= 1'b0;
                end else if (wr_hit) begin
                    pend_h <= cfg_half;
                    pend   <= 1'b1;
                end else if (pend && !run) begin
                    act_h <= pend_h;
                    pend  <= 1'b0;
                end

                if (sync || !run) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (tc) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= ~clk_q;
                end else begin
                    cnt    <= cnt + CNT_W'(1);
                    tick_q <= 1'b0;
                end
            end
        end

        assign clk_out[i]     = clk_q;
        assign tick[i]        = tick_q;
        assign cfg_pending[i] = pend;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with three channels (so cfg_ch=3 is out of range).
module tb_clock_divider_bank;
    localparam int NUM_CH     = 3;
    localparam int CNT_W      = 16;
    localparam int RESET_HALF = 5;
    localparam int CH_W       = 2;

    logic              clock1M = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] cfg_pending;

    int checks   = 0;
    int failures = 0;

    clock_divider_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .RESET_HALF(RESET_HALF)
    ) dut (
        .clock1M    (clock1M),
        .reset      (reset),
        .en         (en),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_half   (cfg_half),
        .clk_out    (clk_out),
        .tick       (tick),
        .cfg_pending(cfg_pending)
    );

    initial forever #5 clock1M = ~clock1M;

    // k = edges since the channel started counting from cnt=0 with half-period h.
    function automatic logic lvl(int k, int h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic logic tk(int k, int h);
        return (k % (2 * h)) == h;
    endfunction

    function automatic logic [2:0] vlvl(int k, int h0, int h1, int h2);
        return {lvl(k, h2), lvl(k, h1), lvl(k, h0)};
    endfunction

    function automatic logic [2:0] vtk(int k, int h0, int h1, int h2);
        return {tk(k, h2), tk(k, h1), tk(k, h0)};
    endfunction

    task automatic step();
        @(posedge clock1M);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = '1; sync = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({clk_out, tick, cfg_pending} !== 9'b0) begin
                failures++;
                $display("FAIL reset_outputs k=%0d got=%b required=%b", k, {clk_out, tick, cfg_pending}, 9'b0);
            end
        end
    endtask

    task automatic test_default();
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (clk_out !== vlvl(k, 5, 5, 5) || tick !== vtk(k, 5, 5, 5)) begin
                failures++;
                $display("FAIL default_100k k=%0d got clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out, tick, vlvl(k, 5, 5, 5), vtk(k, 5, 5, 5));
            end
        end
    endtask

    task automatic test_cfg_disabled();
        en = 3'b101;
        step();
        checks++;
        if (clk_out[1] !== 1'b0) begin
            failures++;
            $display("FAIL disable_low got=%b required=0", clk_out[1]);
        end
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_half = 16'd50;
        step();
        cfg_we = 1'b0;
        checks++;
        if (cfg_pending !== 3'b010) begin
            failures++;
            $display("FAIL pend_set_disabled got=%b required=010", cfg_pending);
        end
        step();
        checks++;
        if (cfg_pending !== 3'b000) begin
            failures++;
            $display("FAIL pend_clear_disabled got=%b required=000", cfg_pending);
        end
        en = 3'b111; sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (clk_out !== 3'b000) begin
            failures++;
            $display("FAIL enable_sync_low got=%b required=000", clk_out);
        end
        for (int k = 1; k <= 200; k++) begin
            step();
            checks++;
            if (clk_out !== vlvl(k, 5, 50, 5) || tick !== vtk(k, 5, 50, 5)) begin
                failures++;
                $display("FAIL ch1_10k k=%0d got clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out, tick, vlvl(k, 5, 50, 5), vtk(k, 5, 50, 5));
            end
        end
    endtask

    task automatic test_midphase_reprogram();
        logic el, et, ep;
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cfg_we = (k == 7); cfg_ch = 2'd0; cfg_half = 16'd2;
            step();
            if (k < 10) begin
                el = lvl(k, 5); et = (k == 5);
            end else begin
                el = lvl(k - 10, 2); et = ((k - 10) % 4 == 2);
            end
            ep = (k >= 7 && k < 10);
            checks++;
            if (clk_out[0] !== el || tick[0] !== et || cfg_pending[0] !== ep || clk_out[2] !== lvl(k, 5)) begin
                failures++;
                $display("FAIL midphase k=%0d got clk0=%b tick0=%b pend0=%b clk2=%b required %b %b %b %b",
                         k, clk_out[0], tick[0], cfg_pending[0], clk_out[2], el, et, ep, lvl(k, 5));
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_sync_align();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd3;
        step();
        checks++;
        if (cfg_pending !== 3'b001) begin
            failures++;
            $display("FAIL sync_pend_before got=%b required=001", cfg_pending);
        end
        cfg_ch = 2'd2; cfg_half = 16'd7; sync = 1'b1;
        step();
        cfg_we = 1'b0; sync = 1'b0;
        checks++;
        if ({clk_out, tick, cfg_pending} !== 9'b0) begin
            failures++;
            $display("FAIL sync_edge got=%b required=%b", {clk_out, tick, cfg_pending}, 9'b0);
        end
        for (int k = 1; k <= 84; k++) begin
            step();
            checks++;
            if (clk_out !== vlvl(k, 3, 50, 7) || tick !== vtk(k, 3, 50, 7)) begin
                failures++;
                $display("FAIL sync_align k=%0d got clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out, tick, vlvl(k, 3, 50, 7), vtk(k, 3, 50, 7));
            end
        end
    endtask

    task automatic test_h0_h1();
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_half = 16'd0; sync = 1'b1;
        step();
        cfg_we = 1'b0; sync = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0 || cfg_pending[0] !== 1'b0) begin
                failures++;
                $display("FAIL h0_off k=%0d got clk0=%b tick0=%b pend0=%b required 0 0 0",
                         k, clk_out[0], tick[0], cfg_pending[0]);
            end
        end
        cfg_we = 1'b1; cfg_half = 16'd1;
        step();
        cfg_we = 1'b0;
        checks++;
        if (cfg_pending[0] !== 1'b1) begin
            failures++;
            $display("FAIL h1_pend_set got=%b required=1", cfg_pending[0]);
        end
        step();
        checks++;
        if (cfg_pending[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL h1_apply got pend0=%b clk0=%b required 0 0", cfg_pending[0], clk_out[0]);
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (clk_out[0] !== lvl(j, 1) || tick[0] !== tk(j, 1)) begin
                failures++;
                $display("FAIL h1_toggle j=%0d got clk0=%b tick0=%b required %b %b",
                         j, clk_out[0], tick[0], lvl(j, 1), tk(j, 1));
            end
        end
    endtask

    task automatic test_bad_channel();
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_half = 16'd9;
        step();
        cfg_we = 1'b0;
        checks++;
        if (cfg_pending !== 3'b000) begin
            failures++;
            $display("FAIL bad_ch_pend got=%b required=000", cfg_pending);
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if (clk_out !== vlvl(k, 1, 50, 7) || tick !== vtk(k, 1, 50, 7)) begin
                failures++;
                $display("FAIL bad_ch_nochange k=%0d got clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out, tick, vlvl(k, 1, 50, 7), vtk(k, 1, 50, 7));
            end
        end
    endtask

    task automatic test_reset_mid_and_disable();
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_half = 16'd4;
        step();
        cfg_we = 1'b0;
        checks++;
        if (cfg_pending !== 3'b100 || clk_out[2] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got pend=%b clk2=%b required pend=100 clk2=1", cfg_pending, clk_out[2]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({clk_out, tick, cfg_pending} !== 9'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b required=%b", {clk_out, tick, cfg_pending}, 9'b0);
        end
        for (int k = 1; k <= 26; k++) begin
            step();
            checks++;
            if (clk_out !== vlvl(k, 5, 5, 5) || tick !== vtk(k, 5, 5, 5)) begin
                failures++;
                $display("FAIL after_reset k=%0d got clk=%b tick=%b required clk=%b tick=%b",
                         k, clk_out, tick, vlvl(k, 5, 5, 5), vtk(k, 5, 5, 5));
            end
        end
        en = 3'b110;
        step();
        checks++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            failures++;
            $display("FAIL disable_mid got clk0=%b tick0=%b required 0 0", clk_out[0], tick[0]);
        end
        en = 3'b111;
        for (int j = 1; j <= 10; j++) begin
            step();
            checks++;
            if (clk_out[0] !== lvl(j, 5) || tick[0] !== tk(j, 5)) begin
                failures++;
                $display("FAIL reenable j=%0d got clk0=%b tick0=%b required %b %b",
                         j, clk_out[0], tick[0], lvl(j, 5), tk(j, 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_cfg_disabled();
        test_midphase_reprogram();
        test_sync_align();
        test_h0_h1();
        test_bad_channel();
        test_reset_mid_and_disable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Parametrised, runtime-programmable bank of NUM_CH clock dividers driven from the 1 MHz system clock. Each channel produces a 50 %-duty divided clock and a one-cycle rising-edge tick. Divide ratios can be reprogrammed glitch-free, and a common sync pulse phase-aligns all channels. It generalises the fixed 10 kHz / 100 kHz dividers and sits between the clock source and any logic needing slow clocks or strobes.

## Interface
- NUM_CH, 2: number of divider channels (1..16)
- CNT_W, 16: width of half-period counters and config values
- RESET_HALF, 5: half-period loaded into every channel at reset (5 → 100 kHz from 1 MHz)
- CH_W, $clog2(NUM_CH) (min 1): channel-select width (derived, not overridden)

One clock; reset is synchronous and active-high.

- clock1M  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel enable
- sync  in  1  one-cycle pulse; restarts all channels in phase
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  target channel of write
- cfg_half  in  CNT_W  new half-period H (clock1M cycles per output half-period)
- clk_out  out  NUM_CH  divided clocks, registered
- tick  out  NUM_CH  one-cycle pulse, high in the same cycle clk_out[i] first goes high
- cfg_pending  out  NUM_CH  write accepted, not yet applied

## Operation
- Per channel: active half-period act_h, pending value pend_h plus pend flag, counter cnt (CNT_W), output reg, tick reg.
- Reset (sync): cnt=0, clk_out=0, tick=0, act_h=RESET_HALF, pend flags=0, cfg_pending=0.
- Running (en[i]=1, act_h≥1): each edge, if cnt==act_h-1 then cnt←0 and clk_out toggles, else cnt←cnt+1. Output period 2·H cycles, 50 % duty. H=1 gives clock1M/2.
- tick[i]←1 on the edge where clk_out[i] goes 0→1, else 0.
- Disabled (en[i]=0) or act_h==0: cnt←0, clk_out←0, tick←0. H=0 is the defined "off" setting.
- Config write: cfg_we with cfg_ch<NUM_CH sets pend_h[cfg_ch]=cfg_half and pend=1. cfg_ch≥NUM_CH is ignored. A second write before application overwrites; last value wins.
- Application of pending value (clears pend), in this priority order:
  1. Immediately, on the next edge, if the channel is disabled or act_h==0.
  2. On a sync edge.
  3. Otherwise only at the terminal-count edge where clk_out toggles 1→0. The new H governs the next low half, so no runt pulses occur.
- sync: every channel gets cnt←0, clk_out←0, tick←0. Pending values are applied on that edge. Enabled channels then rise H edges later, all aligned.
- Simultaneous events:
  - reset beats everything.
  - sync beats a terminal count in the same cycle.
  - cfg_we and sync in the same cycle: the new value is applied by that sync.
  - cfg_we at a channel's 1→0 terminal-count edge: the new value is applied on that edge.
- Counter never exceeds act_h-1. No wrap beyond 2^CNT_W-1 (max H = 2^CNT_W-1).

## Timing
- All outputs registered; no combinational input→output paths.
- From the first edge with en[i]=1 (cnt=0): clk_out rises at the H-th enabled edge. tick asserts on that same edge for one cycle.
- From sync at edge s: clk_out rises at edge s+H for each enabled channel.
- Disable: clk_out=0 one edge after en falls. Re-enable restarts from cnt=0.
- cfg_pending goes high the edge after cfg_we and low on the application edge.
- Reset mid-operation: all outputs 0 on the next edge, including in-flight ticks. Config returns to RESET_HALF.

## Test plan
- Reset, en=all-1, no writes → every clk_out has period 10 cycles (5 high/5 low); tick once per 10 cycles coincident with the rise; all outputs 0 during reset.
- Write ch1 H=50 while disabled, then enable → cfg_pending[1] clears next edge; clk_out[1] period 100 cycles (10 kHz); ch0 unchanged at 100 kHz.
- Ch0 running H=5, write H=2 mid-high-phase → current high phase stays 5 cycles; then low 2 / high 2; no pulse shorter than 2 cycles; cfg_pending[0] clears on the 1→0 edge.
- Channels with H=3 and H=7 free-running, pulse sync → both clk_out low next edge; rise at s+3 and s+7; tick edges then align every 42 cycles.
- Write H=0 → clk_out held 0, tick never fires. Write H=1 → toggles every cycle. Write to cfg_ch=NUM_CH → no state change.
- Assert reset mid-high-phase with a write pending → next edge all outputs 0, cfg_pending=0; after release, H=RESET_HALF behaviour resumes.
